// File: rtl/ldst_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store initiator.
// Size codes, FSM states and lane masks used by ldst_unit and ldst_lane.
package ldst_pkg;

   localparam int DW = 64;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_RESP
   } state_t;

   // Right-aligned mask covering one lane of the given size.
   function automatic logic [DW-1:0] lane_mask(input logic [1:0] size);
      logic [DW-1:0] m;
      m = '0;
      case (size)
         SZ_B:    m = 64'h0000_0000_0000_00FF;
         SZ_H:    m = 64'h0000_0000_0000_FFFF;
         SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
         default: m = '1;
      endcase
      return m;
   endfunction

   function automatic logic misaligned(input logic [1:0] size,
                                       input logic [2:0] off);
      logic m;
      m = 1'b0;
      case (size)
         SZ_B:    m = 1'b0;
         SZ_H:    m = off[0];
         SZ_W:    m = |off[1:0];
         default: m = |off;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ldst_lane.sv
// Combinational lane logic: little-endian extract/extend for loads and
// lane merge into a captured word for read-modify-write stores.
module ldst_lane
   import ldst_pkg::*;
#(
   parameter int BITSIZE  = 64,
   parameter int OFF_BITS = 3
) (
   input  logic [BITSIZE-1:0]  word,
   input  logic [BITSIZE-1:0]  wdata,
   input  logic [1:0]          size,
   input  logic [OFF_BITS-1:0] off,
   input  logic                sign_ext,
   output logic [BITSIZE-1:0]  rdata,
   output logic [BITSIZE-1:0]  merged
);

   logic [OFF_BITS+2:0] sh;
   logic [BITSIZE-1:0]  lane;
   logic [BITSIZE-1:0]  mask;

   assign sh     = {off, 3'b000};
   assign lane   = word >> sh;
   assign mask   = BITSIZE'(lane_mask(size)) << sh;
   assign merged = (word & ~mask) | ((wdata << sh) & mask);

   always_comb begin
      rdata = '0;
      case (size)
         SZ_B: rdata = {{(BITSIZE-8){sign_ext & lane[7]}}, lane[7:0]};
         SZ_H: rdata = {{(BITSIZE-16){sign_ext & lane[15]}}, lane[15:0]};
         SZ_W: rdata = {{(BITSIZE-32){sign_ext & lane[31]}}, lane[31:0]};
         default: rdata = lane;
      endcase
   end

endmodule

// File: rtl/ldst_unit.sv
// MEM-stage load/store requester driving a word-addressed Data_Memory;
// sub-dword stores are done as read-modify-write.
module ldst_unit
   import ldst_pkg::*;
#(
   parameter int BITSIZE  = 64,
   parameter int OFF_BITS = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [1:0]         req_size,
   input  logic               req_signed,
   input  logic [BITSIZE-1:0] req_addr,
   input  logic [BITSIZE-1:0] req_wdata,
   output logic               resp_valid,
   output logic [BITSIZE-1:0] resp_rdata,
   output logic               resp_err,
   output logic [BITSIZE-1:0] address,
   output logic [BITSIZE-1:0] writeData,
   output logic               memWrite,
   output logic               memRead,
   input  logic [BITSIZE-1:0] readData
);

   state_t              state;
   logic                r_write;
   logic                r_signed;
   logic [1:0]          r_size;
   logic [OFF_BITS-1:0] r_off;
   logic [BITSIZE-1:0]  r_wdata;
   logic [BITSIZE-1:0]  r_data;
   logic                r_err;
   logic                wr_q;
   logic [BITSIZE-1:0]  lane_rdata;
   logic [BITSIZE-1:0]  lane_merged;

   ldst_lane #(
      .BITSIZE  (BITSIZE),
      .OFF_BITS (OFF_BITS)
   ) u_lane (
      .word     (readData),
      .wdata    (r_wdata),
      .size     (r_size),
      .off      (r_off),
      .sign_ext (r_signed),
      .rdata    (lane_rdata),
      .merged   (lane_merged)
   );

   // A reset arriving on the write edge must not let the word be committed.
   assign memWrite = wr_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         address    <= '0;
         writeData  <= '0;
         wr_q       <= 1'b0;
         memRead    <= 1'b0;
         r_write    <= 1'b0;
         r_signed   <= 1'b0;
         r_size     <= SZ_B;
         r_off      <= '0;
         r_wdata    <= '0;
         r_data     <= '0;
         r_err      <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  r_write   <= req_write;
                  r_size    <= req_size;
                  r_signed  <= req_signed;
                  r_off     <= req_addr[OFF_BITS-1:0];
                  r_wdata   <= req_wdata;
                  r_data    <= '0;
                  req_ready <= 1'b0;
                  if (misaligned(req_size, req_addr[OFF_BITS-1:0])) begin
                     r_err <= 1'b1;
                     state <= S_RESP;
                  end else begin
                     r_err   <= 1'b0;
                     address <= {req_addr[BITSIZE-1:OFF_BITS],
                                 {OFF_BITS{1'b0}}};
                     if (req_write && req_size == SZ_D) begin
                        writeData <= req_wdata;
                        wr_q      <= 1'b1;
                        state     <= S_WR;
                     end else begin
                        memRead <= 1'b1;
                        state   <= S_RD;
                     end
                  end
               end
            end
            S_RD: begin
               memRead <= 1'b0;
               state   <= S_CAP;
            end
            S_CAP: begin
               if (r_write) begin
                  writeData <= lane_merged;
                  wr_q      <= 1'b1;
                  state     <= S_WR;
               end else begin
                  r_data <= lane_rdata;
                  state  <= S_RESP;
               end
            end
            S_WR: begin
               wr_q  <= 1'b0;
               state <= S_RESP;
            end
            S_RESP: begin
               resp_valid <= 1'b1;
               resp_rdata <= r_data;
               resp_err   <= r_err;
               req_ready  <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ldst_unit.sv
// Directed bench for ldst_unit with a simple word-addressed memory model
// that registers reads and commits writes on the rising edge.
module tb_ldst_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [63:0] address;
   logic [63:0] writeData;
   logic        memWrite;
   logic        memRead;
   logic [63:0] readData;

   logic [63:0] mem [0:31];

   int checks = 0;
   int errors = 0;
   int lat;
   int rdc;
   int wrc;
   int both;

   always #5 clk = ~clk;

   ldst_unit #(.BITSIZE(64), .OFF_BITS(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .address    (address),
      .writeData  (writeData),
      .memWrite   (memWrite),
      .memRead    (memRead),
      .readData   (readData)
   );

   always @(posedge clk) begin
      if (memWrite) mem[address[7:3]] <= writeData;
      if (memRead) readData <= mem[address[7:3]];
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge showing resp_valid.
   task automatic do_req(input logic w, input logic [1:0] sz,
                         input logic sg, input logic [63:0] a,
                         input logic [63:0] d);
      int n;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = d;
      req_valid  = 1'b1;
      lat  = -1;
      rdc  = 0;
      wrc  = 0;
      both = 0;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (memRead) rdc++;
         if (memWrite) wrc++;
         if (memRead && memWrite) both++;
         if (resp_valid) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int accepts;
      int resps;
      int viol;
      int busy;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_rdata", resp_rdata, 64'd0);
      chk("rst_err", 64'(resp_err), 64'd0);
      chk("rst_address", address, 64'd0);
      chk("rst_wdata", writeData, 64'd0);
      chk("rst_memrw", {62'd0, memRead, memWrite}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // T1: dword store then dword load
      do_req(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788);
      chk("t1_st_lat", 64'(lat), 64'd2);
      chk("t1_st_err", 64'(resp_err), 64'd0);
      chk("t1_st_rdata", resp_rdata, 64'd0);
      chk("t1_st_rd", 64'(rdc), 64'd0);
      chk("t1_st_wr", 64'(wrc), 64'd1);
      chk("t1_mem", mem[2], 64'h1122334455667788);
      do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
      chk("t1_ld_lat", 64'(lat), 64'd3);
      chk("t1_ld_rdata", resp_rdata, 64'h1122334455667788);
      chk("t1_ld_err", 64'(resp_err), 64'd0);

      // T2: byte store via read-modify-write
      do_req(1'b1, 2'd0, 1'b0, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB);
      chk("t2_lat", 64'(lat), 64'd4);
      chk("t2_rd", 64'(rdc), 64'd1);
      chk("t2_wr", 64'(wrc), 64'd1);
      chk("t2_both", 64'(both), 64'd0);
      chk("t2_mem", mem[2], 64'h11223344AB667788);

      // T3: sub-dword loads
      do_req(1'b0, 2'd0, 1'b1, 64'h13, 64'h0);
      chk("t3_sb", resp_rdata, 64'hFFFFFFFFFFFFFFAB);
      chk("t3_sb_lat", 64'(lat), 64'd3);
      do_req(1'b0, 2'd0, 1'b0, 64'h13, 64'h0);
      chk("t3_ub", resp_rdata, 64'h00000000000000AB);
      do_req(1'b0, 2'd1, 1'b1, 64'h16, 64'h0);
      chk("t3_sh", resp_rdata, 64'h0000000000001122);
      do_req(1'b0, 2'd2, 1'b1, 64'h10, 64'h0);
      chk("t3_sw", resp_rdata, 64'hFFFFFFFFAB667788);

      // T4: misaligned word load
      do_req(1'b0, 2'd2, 1'b1, 64'h12, 64'h0);
      chk("t4_lat", 64'(lat), 64'd1);
      chk("t4_err", 64'(resp_err), 64'd1);
      chk("t4_rdata", resp_rdata, 64'd0);
      chk("t4_rd", 64'(rdc), 64'd0);
      chk("t4_wr", 64'(wrc), 64'd0);

      // T5: reset during CAP of a half store
      req_write  = 1'b1;
      req_size   = 2'd1;
      req_signed = 1'b0;
      req_addr   = 64'h10;
      req_wdata  = 64'hBEEF;
      req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("t5_c0_rd", 64'(memRead), 64'd1);
      @(negedge clk);
      chk("t5_c1_wr", 64'(memWrite), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_ready", 64'(req_ready), 64'd1);
      chk("t5_rst_memrw", {62'd0, memRead, memWrite}, 64'd0);
      chk("t5_rst_addr", address, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("t5_post_wr", 64'(memWrite), 64'd0);
      repeat (3) @(negedge clk);
      chk("t5_mem", mem[2], 64'h11223344AB667788);

      // T6: req_valid held high across three loads
      accepts = 0;
      resps   = 0;
      viol    = 0;
      busy    = 0;
      req_write  = 1'b0;
      req_size   = 2'd3;
      req_signed = 1'b0;
      req_addr   = 64'h10;
      req_valid  = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (resp_valid) begin
            resps++;
            busy = 0;
         end
         if (busy != 0 && req_ready) viol++;
         if (req_valid && req_ready) begin
            accepts++;
            busy = 1;
         end
         @(negedge clk);
         if (accepts == 3) req_valid = 1'b0;
      end
      chk("t6_accepts", 64'(accepts), 64'd3);
      chk("t6_resps", 64'(resps), 64'd3);
      chk("t6_ready_busy", 64'(viol), 64'd0);
      chk("t6_rdata", resp_rdata, 64'h11223344AB667788);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
